load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the single-cycle core's execute/ALU stage and the data memory.
- Converts core load/store requests (byte, halfword, word; signed/unsigned loads) into word-only memory accesses.
- Sub-word stores use read-modify-write; lane extraction and sign extension are done locally.
- Handles the memory's combinational-read settling delay with a wait counter and raises faults for misaligned or out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h10000000, first valid byte address of data memory.
- DEPTH_WORDS, 32, number of 32-bit words in data memory.
- WAIT_CYCLES, 3, cycles mem_read_out is held before read data is sampled; legal range is at least 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_in  in  1  request strobe, sampled only in IDLE.
- we_in  in  1  1 = store, 0 = load.
- size_in  in  2  00 byte, 01 half, 10 word, 11 illegal.
- signed_in  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr_in  in  32  byte address.
- wdata_in  in  32  store data, right-justified.
- busy_out  out  1  high whenever state is not IDLE.
- done_out  out  1  one-cycle completion pulse.
- fault_out  out  1  valid with done_out; 1 = request rejected.
- rdata_out  out  32  load result.
- mem_addr_out  out  32  word-aligned memory address.
- mem_read_out  out  1  memory read enable.
- mem_write_out  out  1  memory write enable.
- mem_wdata_out  out  32  memory write data.
- mem_rdata_in  in  32  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n), and forces state IDLE with all outputs 0.
- Reset mid-operation:
  - Aborts immediately and drops mem_write_out.
  - A write whose capturing edge has not yet occurred must not happen.
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE: latch addr/we/size/signed/wdata when req_in=1 at a posedge (edge E0).
- Fault check at E0:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - addr < BASE_ADDR, or addr > BASE_ADDR+4*DEPTH_WORDS-1.
  - On fault: go to DONE with fault_out=1, no memory strobes, rdata_out unchanged.
- Transitions out of IDLE (non-fault):
  - Load or sub-word store: go to RD_WAIT.
  - Word store: go to WR.
- Memory address: mem_addr_out = {addr[31:2],2'b00}, driven from E0 through the end of DONE; 0 in IDLE.
- RD_WAIT:
  - mem_read_out=1 for exactly WAIT_CYCLES cycles.
  - At edge E0+WAIT_CYCLES, sample mem_rdata_in.
  - Load: go to DONE. Sub-word store: go to WR.
- Little-endian lanes:
  - byte k = bits [8k+7:8k], with k = addr[1:0].
  - half at addr[1] = bits [16*addr[1]+15 : 16*addr[1]].
- Load result:
  - Selected lane is sign- or zero-extended per signed_in.
  - Word loads ignore signed_in.
  - rdata_out is updated at the DONE entry edge and held until the next successful load.
- WR:
  - mem_write_out=1 for exactly one cycle.
  - mem_wdata_out = wdata_in for word stores.
  - For sub-word stores, mem_wdata_out = sampled word with only the target lane replaced by wdata[7:0] or wdata[15:0].
  - Next state DONE.
  - mem_wdata_out holds its value through DONE and is 0 in IDLE.
- DONE: done_out=1 for one cycle, then IDLE; a new request can be accepted on the next edge.
- req_in is ignored while busy_out=1; no queueing.
- Latency from E0 to the done_out rising edge:
  - load: WAIT_CYCLES
  - word store: 1
  - sub-word store: WAIT_CYCLES+1
  - fault: 1
- mem_read_out and mem_write_out are never both high.

Test Plan:
- Reset low mid-RD_WAIT for a store byte → IDLE immediately; no mem_write_out pulse; outputs 0; after release, the first request completes normally.
- Memory word 0x10000008 = 0x8081F2A3, WAIT_CYCLES=3:
  - lb 0x10000009 → done after 3 cycles, rdata 0xFFFFFFF2.
  - lbu same address → 0x000000F2.
  - lh 0x1000000A → 0xFFFF8081.
  - lw 0x10000008 → 0x8081F2A3.
- sb 0x10000005, wdata 0x000000AB, old word 0x11223344 → one mem_write_out pulse with data 0x1122AB44, done at cycle 4.
- sw 0x1000007C, data 0xDEADBEEF → mem_write_out one cycle at address 0x1000007C, done_out the following cycle, no mem_read_out.
- Fault cases, each → fault_out=1 with done_out after 1 cycle, no memory strobes:
  - lw 0x10000002 (misaligned).
  - sh 0x10000003 (misaligned).
  - lw 0x10000080 (out of range).
  - size 11 (illegal).
- req_in held high across a load → second request accepted only on the edge after DONE; exactly two done_out pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into word-only memory accesses,
// using read-modify-write for sub-word stores and a fixed settling wait for reads.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        fault_out,
  output logic [31:0] rdata_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [31:0] LastAddr = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;
  localparam int unsigned CntW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWr, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      addr_lo_q;
  logic [1:0]      size_q;
  logic            we_q;
  logic            signed_q;
  logic [15:0]     wdata_q;
  logic            fault_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;

  logic        req_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    req_fault = 1'b0;
    unique case (size_in)
      2'b00:   req_fault = 1'b0;
      2'b01:   req_fault = addr_in[0];
      2'b10:   req_fault = (addr_in[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
    if ((addr_in < BASE_ADDR) || (addr_in > LastAddr)) req_fault = 1'b1;
  end

  always_comb begin
    lane_b   = mem_rdata_in[{addr_lo_q, 3'b000} +: 8];
    lane_h   = mem_rdata_in[{addr_lo_q[1], 4'b0000} +: 16];
    load_val = mem_rdata_in;
    merged   = mem_rdata_in;
    if (size_q == 2'b00) begin
      load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      if (size_q == 2'b01) load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_in) begin
            addr_lo_q  <= addr_in[1:0];
            size_q     <= size_in;
            we_q       <= we_in;
            signed_q   <= signed_in;
            wdata_q    <= wdata_in[15:0];
            fault_q    <= req_fault;
            mem_addr_q <= {addr_in[31:2], 2'b00};
            cnt_q      <= CntW'(WAIT_CYCLES - 1);
            // A rejected request spends one strobe-free cycle in WR so its
            // done pulse lands one cycle after acceptance, like a word store.
            if (req_fault) begin
              state_q <= StWr;
            end else if (we_in && (size_in == 2'b10)) begin
              mem_wdata_q <= wdata_in;
              state_q     <= StWr;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (cnt_q == '0) begin
            if (we_q) begin
              mem_wdata_q <= merged;
              state_q     <= StWr;
            end else begin
              rdata_q <= load_val;
              state_q <= StDone;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWr: state_q <= StDone;
        StDone: begin
          state_q     <= StIdle;
          fault_q     <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_out      = (state_q != StIdle);
  assign done_out      = (state_q == StDone);
  assign fault_out     = (state_q == StDone) && fault_q;
  assign mem_read_out  = (state_q == StRdWait);
  assign mem_write_out = (state_q == StWr) && !fault_q;
  assign rdata_out     = rdata_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a word-array model.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DEPTH = 32;
  localparam int W = 3;

  logic        clk, rst_n, req_in, we_in, signed_in;
  logic [1:0]  size_in;
  logic [31:0] addr_in, wdata_in;
  logic        busy_out, done_out, fault_out, mem_read_out, mem_write_out;
  logic [31:0] rdata_out, mem_addr_out, mem_wdata_out, mem_rdata_in;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] model_rdata;

  int n_checks = 0;
  int n_fail = 0;

  int          obs_lat, obs_reads, obs_writes, obs_both;
  logic        obs_fault, obs_timeout;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;

  load_store_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .we_in(we_in), .size_in(size_in),
    .signed_in(signed_in), .addr_in(addr_in), .wdata_in(wdata_in), .busy_out(busy_out),
    .done_out(done_out), .fault_out(fault_out), .rdata_out(rdata_out),
    .mem_addr_out(mem_addr_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read data memory.
  logic [31:0] rd_off;
  always_comb begin
    rd_off = mem_addr_out - BASE;
    mem_rdata_in = 32'h0;
    if (mem_addr_out >= BASE && rd_off < 32'(4 * DEPTH)) mem_rdata_in = mem[rd_off[6:2]];
  end

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'(4 * DEPTH) - 32'd1);
  endfunction

  // Reference behaviour: fault rules, latencies and lane arithmetic on a word array.
  task automatic model_op(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic f,
                          output int lat, output int rds, output int wrs,
                          output logic [31:0] wword);
    logic [31:0] off, old, sft, mask;
    int sh, v;
    f = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || !in_range(a);
    lat = 1; rds = 0; wrs = 0; wword = 32'h0;
    if (!f) begin
      off = a - BASE;
      old = ref_mem[off[6:2]];
      sh = 8 * int'(a[1:0]);
      sft = old >> sh;
      if (!we) begin
        lat = W; rds = W;
        if (sz == 2'd0) begin
          v = int'(sft[7:0]);
          if (sg && v >= 128) v = v - 256;
          model_rdata = 32'(v);
        end else if (sz == 2'd1) begin
          v = int'(sft[15:0]);
          if (sg && v >= 32768) v = v - 65536;
          model_rdata = 32'(v);
        end else begin
          model_rdata = old;
        end
      end else begin
        wrs = 1;
        if (sz == 2'd2) begin
          wword = wd;
        end else begin
          lat = W + 1; rds = W;
          mask = (sz == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
          wword = (old & ~mask) | ((wd << sh) & mask);
        end
        ref_mem[off[6:2]] = wword;
      end
    end
  endtask

  // Issue one request from an idle DUT and record what it does; returns idle, #1 after an edge.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off;
    req_in = 1'b1; we_in = we; size_in = sz; signed_in = sg; addr_in = a; wdata_in = wd;
    @(posedge clk); #1;
    req_in = 1'b0;
    obs_addr = mem_addr_out;
    obs_lat = 0; obs_reads = 0; obs_writes = 0; obs_both = 0; obs_wdata = 32'h0;
    while (!done_out && obs_lat < 20) begin
      if (mem_read_out) obs_reads++;
      if (mem_read_out && mem_write_out) obs_both++;
      if (mem_write_out) begin
        obs_writes++;
        obs_wdata = mem_wdata_out;
        off = mem_addr_out - BASE;
        if (in_range(mem_addr_out)) mem[off[6:2]] = mem_wdata_out;
      end
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_timeout = !done_out;
    obs_fault = fault_out;
    obs_rdata = rdata_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if ({busy_out, done_out, fault_out, mem_read_out, mem_write_out} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000",
        {busy_out, done_out, fault_out, mem_read_out, mem_write_out}); end
    n_checks++; if ({rdata_out, mem_addr_out, mem_wdata_out} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h expected 0",
        rdata_out, mem_addr_out, mem_wdata_out); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy_out); end
  endtask

  task automatic test_loads();
    logic [1:0] szs [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic sgs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addrs [4] = '{32'h1000_0009, 32'h1000_0009, 32'h1000_000A, 32'h1000_0008};
    logic [31:0] exps [4] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'hFFFF_8081, 32'h8081_F2A3};
    logic f; int lat, rds, wrs; logic [31:0] ww;
    mem[2] = 32'h8081_F2A3; ref_mem[2] = 32'h8081_F2A3;
    for (int i = 0; i < 4; i++) begin
      model_op(1'b0, szs[i], sgs[i], addrs[i], 32'h0, f, lat, rds, wrs, ww);
      run_op(1'b0, szs[i], sgs[i], addrs[i], 32'h0);
      n_checks++; if (obs_rdata !== exps[i]) begin
        n_fail++; $display("FAIL load_%0d_rdata: got %h expected %h", i, obs_rdata, exps[i]); end
      n_checks++; if (obs_lat !== 3 || obs_reads !== 3 || obs_writes !== 0) begin
        n_fail++; $display("FAIL load_%0d_timing: lat %0d reads %0d writes %0d expected 3 3 0",
          i, obs_lat, obs_reads, obs_writes); end
    end
  endtask

  task automatic test_sub_store();
    logic f; int lat, rds, wrs; logic [31:0] ww;
    mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
    model_op(1'b1, 2'd0, 1'b0, 32'h1000_0005, 32'h0000_00AB, f, lat, rds, wrs, ww);
    run_op(1'b1, 2'd0, 1'b0, 32'h1000_0005, 32'h0000_00AB);
    n_checks++; if (obs_writes !== 1 || obs_wdata !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL sb_write: writes %0d data %h expected 1 1122ab44",
        obs_writes, obs_wdata); end
    n_checks++; if (obs_lat !== 4 || obs_both !== 0) begin
      n_fail++; $display("FAIL sb_latency: lat %0d both %0d expected 4 0", obs_lat, obs_both); end
    n_checks++; if (mem[1] !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[1]); end
  endtask

  task automatic test_word_store();
    logic f; int lat, rds, wrs; logic [31:0] ww;
    model_op(1'b1, 2'd2, 1'b0, 32'h1000_007C, 32'hDEAD_BEEF, f, lat, rds, wrs, ww);
    run_op(1'b1, 2'd2, 1'b0, 32'h1000_007C, 32'hDEAD_BEEF);
    n_checks++; if (obs_lat !== 1 || obs_reads !== 0 || obs_writes !== 1) begin
      n_fail++; $display("FAIL sw_timing: lat %0d reads %0d writes %0d expected 1 0 1",
        obs_lat, obs_reads, obs_writes); end
    n_checks++; if (obs_addr !== 32'h1000_007C || mem[31] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_data: addr %h mem %h expected 1000007c deadbeef",
        obs_addr, mem[31]); end
    n_checks++; if (mem_addr_out !== 32'h0 || mem_wdata_out !== 32'h0) begin
      n_fail++; $display("FAIL sw_idle_outputs: addr %h wdata %h expected 0",
        mem_addr_out, mem_wdata_out); end
  endtask

  task automatic test_faults();
    logic wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] szs [4] = '{2'd2, 2'd1, 2'd2, 2'd3};
    logic [31:0] addrs [4] = '{32'h1000_0002, 32'h1000_0003, 32'h1000_0080, 32'h1000_0000};
    for (int i = 0; i < 4; i++) begin
      run_op(wes[i], szs[i], 1'b0, addrs[i], 32'h1234_5678);
      n_checks++; if (obs_fault !== 1'b1 || obs_lat !== 1) begin
        n_fail++; $display("FAIL fault_%0d: fault %b lat %0d expected 1 1", i, obs_fault, obs_lat);
      end
      n_checks++; if (obs_reads !== 0 || obs_writes !== 0 || obs_rdata !== model_rdata) begin
        n_fail++; $display("FAIL fault_%0d_side: reads %0d writes %0d rdata %h expected 0 0 %h",
          i, obs_reads, obs_writes, obs_rdata, model_rdata); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic f; int lat, rds, wrs; logic [31:0] ww;
    int wr_seen = 0;
    mem[5] = 32'h5566_7788; ref_mem[5] = 32'h5566_7788;
    req_in = 1'b1; we_in = 1'b1; size_in = 2'd0; addr_in = 32'h1000_0014; wdata_in = 32'hCC;
    @(posedge clk); #1; req_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++; if ({busy_out, done_out, mem_read_out, mem_write_out} !== 4'b0 ||
                    {rdata_out, mem_addr_out, mem_wdata_out} !== 96'h0) begin
      n_fail++; $display("FAIL midreset_outputs: busy %b rd %b wr %b addr %h rdata %h expected 0",
        busy_out, mem_read_out, mem_write_out, mem_addr_out, rdata_out); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_write_out) wr_seen++;
    end
    rst_n = 1'b1;
    model_rdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_write_out) wr_seen++;
    end
    n_checks++; if (wr_seen !== 0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_write: writes %0d busy %b expected 0 0",
        wr_seen, busy_out); end
    model_op(1'b0, 2'd2, 1'b0, 32'h1000_0014, 32'h0, f, lat, rds, wrs, ww);
    run_op(1'b0, 2'd2, 1'b0, 32'h1000_0014, 32'h0);
    n_checks++; if (obs_rdata !== 32'h5566_7788 || obs_lat !== W || obs_fault !== 1'b0) begin
      n_fail++; $display("FAIL midreset_recover: rdata %h lat %0d fault %b expected 55667788 %0d 0",
        obs_rdata, obs_lat, obs_fault, W); end
  endtask

  task automatic test_back_to_back();
    int dones [$];
    logic f; int lat, rds, wrs; logic [31:0] ww;
    model_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, f, lat, rds, wrs, ww);
    req_in = 1'b1; we_in = 1'b0; size_in = 2'd2; signed_in = 1'b0; addr_in = 32'h1000_0008;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done_out) dones.push_back(k);
      if (k == W + 2) begin
        req_in = 1'b0;
        n_checks++; if (busy_out !== 1'b1) begin
          n_fail++; $display("FAIL held_req_accept: busy %b expected 1", busy_out); end
      end
    end
    n_checks++; if (dones.size() !== 2) begin
      n_fail++; $display("FAIL held_req_count: got %0d done pulses expected 2", dones.size());
    end else begin
      n_checks++; if (dones[0] !== W || dones[1] !== 2 * W + 2) begin
        n_fail++; $display("FAIL held_req_timing: got %0d %0d expected %0d %0d",
          dones[0], dones[1], W, 2 * W + 2); end
    end
    n_checks++; if (rdata_out !== model_rdata) begin
      n_fail++; $display("FAIL held_req_rdata: got %h expected %h", rdata_out, model_rdata); end
  endtask

  task automatic test_random();
    logic f; int lat, rds, wrs; logic [31:0] ww, a, wd, off;
    logic we, sg; logic [1:0] sz; int r;
    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1)); wd = $urandom;
      r = int'($urandom_range(0, 9));
      if (r == 0) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else begin
        a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        if (r > 3 && sz == 2'd1) a[0] = 1'b0;
        if (r > 3 && sz == 2'd2) a[1:0] = 2'b00;
      end
      model_op(we, sz, sg, a, wd, f, lat, rds, wrs, ww);
      run_op(we, sz, sg, a, wd);
      n_checks++; if (obs_timeout || obs_fault !== f || obs_lat !== lat) begin
        n_fail++; $display("FAIL rand_%0d_done: a %h fault %b lat %0d expected fault %b lat %0d",
          i, a, obs_fault, obs_lat, f, lat); end
      n_checks++; if (obs_reads !== rds || obs_writes !== wrs || obs_both !== 0) begin
        n_fail++; $display("FAIL rand_%0d_strobes: reads %0d writes %0d both %0d expected %0d %0d 0",
          i, obs_reads, obs_writes, obs_both, rds, wrs); end
      n_checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_rdata !== model_rdata) begin
        n_fail++; $display("FAIL rand_%0d_data: addr %h rdata %h expected %h %h",
          i, obs_addr, obs_rdata, {a[31:2], 2'b00}, model_rdata); end
      if (wrs == 1) begin
        off = a - BASE;
        n_checks++; if (obs_wdata !== ww || mem[off[6:2]] !== ref_mem[off[6:2]]) begin
          n_fail++; $display("FAIL rand_%0d_store: wdata %h mem %h expected %h",
            i, obs_wdata, mem[off[6:2]], ww); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_in = 1'b0; we_in = 1'b0; size_in = 2'd0; signed_in = 1'b0;
    addr_in = 32'h0; wdata_in = 32'h0; model_rdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_sub_store();
    test_word_store();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
